// File: rtl/ex_mem_elastic_stage.sv
// EX->MEM elastic pipeline stage: valid/ready slot chain with bubble collapse,
// synchronous flush, and an optional one-entry input skid buffer.
module ex_mem_elastic_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 11,
  parameter int unsigned STAGES     = 1,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_W      = $clog2(STAGES + SKID + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0]     v_q, v_d, can_load, pv;
  logic [CTRL_WIDTH-1:0] ctrl_q [STAGES];
  logic [CTRL_WIDTH-1:0] ctrl_d [STAGES];
  logic [CTRL_WIDTH-1:0] pc     [STAGES];
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [DATA_WIDTH-1:0] pd     [STAGES];

  logic                  src_valid;
  logic [CTRL_WIDTH-1:0] src_ctrl;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  in_xfer, out_xfer;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Slot i can load iff out_ready or any slot at or beyond i is empty (bubble collapse).
  always_comb begin : ready_chain
    logic acc;
    acc      = out_ready;
    can_load = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc                = acc | ~v_q[LAST-k];
      can_load[LAST-k]   = acc;
    end
  end

  always_comb begin : feed
    pv    = '0;
    pv[0] = src_valid;
    pc[0] = src_ctrl;
    pd[0] = src_data;
    for (int unsigned i = 1; i < STAGES; i++) begin
      pv[i] = v_q[i-1];
      pc[i] = ctrl_q[i-1];
      pd[i] = data_q[i-1];
    end
  end

  always_comb begin : slot_next
    v_d    = v_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (can_load[i]) begin
        v_d[i] = pv[i];
        if (pv[i]) begin
          ctrl_d[i] = pc[i];
          data_d[i] = pd[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic                  skid_valid_q, skid_valid_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    always_comb begin
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
        if (can_load[0]) skid_valid_d = 1'b0;
      end else if (in_xfer && !can_load[0]) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        skid_valid_q <= 1'b0;
        skid_ctrl_q  <= '0;
        skid_data_q  <= '0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_ctrl_q  <= skid_ctrl_d;
        skid_data_q  <= skid_data_d;
      end
    end

    // in_ready is purely registered; an occupied skid blocks new input.
    assign in_ready  = ~skid_valid_q;
    assign src_valid = skid_valid_q | in_valid;
    assign src_ctrl  = skid_valid_q ? skid_ctrl_q : in_ctrl;
    assign src_data  = skid_valid_q ? skid_data_q : in_data;
  end else begin : g_noskid
    assign in_ready  = can_load[0];
    assign src_valid = in_valid;
    assign src_ctrl  = in_ctrl;
    assign src_data  = in_data;
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_valid = v_q[LAST];
  assign out_xfer  = out_valid & out_ready;
  assign out_ctrl  = v_q[LAST] ? ctrl_q[LAST] : '0;
  assign out_data  = data_q[LAST];
  assign cnt_d     = cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  assign occupancy = cnt_q;

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Self-checking bench: two configurations (STAGES=2/SKID=1 and STAGES=3/SKID=0)
// checked against a FIFO-queue reference model plus directed timing checks.
module tb_ex_mem_elastic_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occupancy;
  logic          b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occupancy;

  ex_mem_elastic_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STAGES(2), .SKID(1)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occupancy));

  ex_mem_elastic_stage #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .STAGES(3), .SKID(0)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occupancy));

  // Reference model: each instance is a FIFO of {ctrl,data} with capacity 3.
  logic [CW+DW-1:0] qa[$];
  logic [CW+DW-1:0] qb[$];
  int unsigned total = 0, passed = 0, failed = 0;
  int unsigned a_acc = 0;
  logic a_pushed, b_pushed;
  int unsigned n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic a_rdy_e, b_rdy_e, a_pop, b_pop, a_hold, b_hold;
    logic [CW+DW-1:0] a_held, b_held;
    #1;
    a_rdy_e = (qa.size() < 3);
    b_rdy_e = (qb.size() < 3) || b_out_ready;
    chk("a_in_ready", a_in_ready, a_rdy_e);
    chk("b_in_ready", b_in_ready, b_rdy_e);
    if (a_in_valid && a_in_ready) a_acc++;
    a_pushed = a_in_valid && a_rdy_e;
    b_pushed = b_in_valid && b_rdy_e;
    a_pop = a_out_valid && a_out_ready;
    b_pop = b_out_valid && b_out_ready;
    if (a_out_valid) begin
      if (qa.size() == 0) chk("a_spurious_out", a_out_valid, 1'b0);
      else chk("a_out_head", {a_out_ctrl, a_out_data}, qa[0]);
    end else chk("a_ctrl_zero", a_out_ctrl, '0);
    if (b_out_valid) begin
      if (qb.size() == 0) chk("b_spurious_out", b_out_valid, 1'b0);
      else chk("b_out_head", {b_out_ctrl, b_out_data}, qb[0]);
    end else chk("b_ctrl_zero", b_out_ctrl, '0);
    a_hold = a_out_valid && !a_out_ready && !a_rst && !a_flush;
    b_hold = b_out_valid && !b_out_ready && !b_rst && !b_flush;
    a_held = {a_out_ctrl, a_out_data};
    b_held = {b_out_ctrl, b_out_data};
    @(posedge clk);
    #1;
    if (a_rst || a_flush) qa.delete();
    else begin
      if (a_pop && qa.size() > 0) void'(qa.pop_front());
      if (a_pushed) qa.push_back({a_in_ctrl, a_in_data});
    end
    if (b_rst || b_flush) qb.delete();
    else begin
      if (b_pop && qb.size() > 0) void'(qb.pop_front());
      if (b_pushed) qb.push_back({b_in_ctrl, b_in_data});
    end
    if (a_hold) chk("a_stable", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, a_held});
    if (b_hold) chk("b_stable", {b_out_valid, b_out_ctrl, b_out_data}, {1'b1, b_held});
    chk("a_occupancy", a_occupancy, qa.size());
    chk("b_occupancy", b_occupancy, qb.size());
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_a_valid"}, a_out_valid, 1'b0);
    chk({tag, "_a_ctrl"}, a_out_ctrl, '0);
    chk({tag, "_a_data"}, a_out_data, '0);
    chk({tag, "_a_occ"}, a_occupancy, '0);
    chk({tag, "_a_ready"}, a_in_ready, 1'b1);
  endtask

  task automatic chk_idle_b(input string tag);
    chk({tag, "_b_valid"}, b_out_valid, 1'b0);
    chk({tag, "_b_ctrl"}, b_out_ctrl, '0);
    chk({tag, "_b_data"}, b_out_data, '0);
    chk({tag, "_b_occ"}, b_occupancy, '0);
    chk({tag, "_b_ready"}, b_in_ready, 1'b1);
  endtask

  task automatic fill_a(input int unsigned cnt);
    a_out_ready = 1'b0;
    for (int c = 0; c < 10 && qa.size() < cnt; c++) begin
      a_in_valid = 1'b1; a_in_ctrl = CW'($urandom); a_in_data = $urandom;
      tick();
    end
    a_in_valid = 1'b0;
    if (qa.size() != cnt) chk("a_fill", qa.size(), cnt);
  endtask

  task automatic fill_b(input int unsigned cnt);
    b_out_ready = 1'b0;
    for (int c = 0; c < 10 && qb.size() < cnt; c++) begin
      b_in_valid = 1'b1; b_in_ctrl = CW'($urandom); b_in_data = $urandom;
      tick();
    end
    b_in_valid = 1'b0;
    if (qb.size() != cnt) chk("b_fill", qb.size(), cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    chk_idle_a("reset");
    chk_idle_b("reset");

    // Stream 0x10..0x17 through A with out_ready held high
    a_out_ready = 1'b1; a_in_valid = 1'b1; n = 0;
    a_in_data = 32'h10; a_in_ctrl = 11'h001;
    for (int c = 0; c < 20 && n < 8; c++) begin
      tick();
      if (n == 0) chk("stream_lat_empty", a_out_valid, 1'b0);
      if (n == 1) chk("stream_first_out", {a_out_valid, a_out_data}, {1'b1, 32'h10});
      if (a_pushed) n++;
      a_in_data = 32'h10 + n; a_in_ctrl = CW'(n + 1);
    end
    a_in_valid = 1'b0;
    chk("stream_accepts", n, 8);
    repeat (4) tick();

    // Backpressure on A: exactly 3 entries accepted in 5 stalled cycles
    a_out_ready = 1'b0; a_in_valid = 1'b1; n = 0;
    a_in_data = 32'h10; a_in_ctrl = 11'h001;
    begin
      int unsigned acc0;
      acc0 = a_acc;
      repeat (5) begin
        tick();
        if (a_pushed) n++;
        a_in_data = 32'h10 + n; a_in_ctrl = CW'(n + 1);
      end
      a_in_valid = 1'b0;
      chk("bp_accepted", a_acc - acc0, 3);
    end
    chk("bp_hold", {a_out_valid, a_out_data}, {1'b1, 32'h10});
    a_out_ready = 1'b1;
    repeat (5) tick();

    // Flush with A full and a coincident input
    fill_a(3);
    a_in_valid = 1'b1; a_in_data = 32'h99; a_in_ctrl = 11'h7ff; a_flush = 1'b1;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk_idle_a("flush");
    a_out_ready = 1'b1;
    repeat (6) tick();

    // Reset mid-stream on A, then a lone 0xAA entry
    fill_a(2);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk_idle_a("midrst");
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hAA; a_in_ctrl = 11'h0AA;
    tick();
    a_in_valid = 1'b0;
    chk("midrst_lat", a_out_valid, 1'b0);
    tick();
    chk("midrst_aa", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 11'h0AA, 32'hAA});
    tick();
    chk("midrst_alone", a_out_valid, 1'b0);

    // Bubble collapse on B: single entry travels to the last slot while stalled
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h55; b_in_ctrl = 11'h003;
    tick();
    b_in_valid = 1'b0;
    chk("bubble_t1", b_out_valid, 1'b0);
    tick();
    chk("bubble_t2", b_out_valid, 1'b0);
    tick();
    chk("bubble_t3", {b_out_valid, b_out_data}, {1'b1, 32'h55});
    chk("bubble_ready", b_in_ready, 1'b1);
    b_out_ready = 1'b1;
    repeat (2) tick();

    // B full, out_ready toggling: in_ready follows out_ready combinationally
    fill_b(3);
    b_in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      b_out_ready = (c % 2 == 1);
      b_in_ctrl = CW'($urandom); b_in_data = $urandom;
      #1;
      chk("toggle_mirror", b_in_ready, b_out_ready);
      tick();
    end
    // Flush on B while an input transfer is actually accepted
    b_out_ready = 1'b1; b_in_data = 32'h77; b_in_ctrl = 11'h077; b_flush = 1'b1;
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk_idle_b("flush");
    repeat (5) tick();

    // Randomized traffic on both instances, with occasional flushes
    for (int c = 0; c < 400; c++) begin
      a_in_valid  = ($urandom_range(0, 1) == 1);
      a_in_ctrl   = CW'($urandom); a_in_data = $urandom;
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 49) == 0);
      b_in_valid  = ($urandom_range(0, 2) != 0);
      b_in_ctrl   = CW'($urandom); b_in_data = $urandom;
      b_out_ready = ($urandom_range(0, 1) == 1);
      b_flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_a_occ", a_occupancy, '0);
    chk("drain_b_occ", b_occupancy, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_mem_elastic_stage.md
# ex_mem_elastic_stage

Parametrised elastic pipeline stage for the EX→MEM boundary of the pipelined core, generalising the fixed stage register. It adds valid/ready flow control, a configurable register depth, synchronous flush with bubble insertion, and an optional input skid buffer that registers the ready path. Control and data fields are carried as separate buses so that a bubble always presents all-zero control, which the core treats as a NOP.

## Interface
Parameters:
- DATA_WIDTH, 32: width of the data payload (ALU result, store data, branch target, concatenated by the instantiator).
- CTRL_WIDTH, 11: width of the control payload (Branch, Jump, byte-size, MemRead/MemWrite, RegWrite, MemtoReg, unsigned_load, etc.).
- STAGES, 1: number of register slots in series, ≥1.
- SKID, 1: 1 = one-entry input skid buffer, 0 = none.
- CNT_W, $clog2(STAGES+SKID+1): occupancy counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block can accept this cycle.
- in_ctrl  in  CTRL_WIDTH  control payload.
- in_data  in  DATA_WIDTH  data payload.
- out_valid  out  1  output entry present.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_WIDTH  control payload, forced 0 when out_valid=0.
- out_data  out  DATA_WIDTH  data payload, 0 after reset/flush until the next entry arrives.
- occupancy  out  CNT_W  entries held (slots plus skid).

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Slot chain v[0..STAGES-1]. Slot STAGES-1 drives the outputs. Slot i may load when it is empty or is draining this cycle. The last slot drains on out_ready. Slot i<STAGES-1 drains when slot i+1 loads. Bubbles collapse, so a stalled tail does not block an empty head.
- SKID=0: in_ready = slot 0 can load (combinational from out_ready through the chain).
- SKID=1: in_ready = !skid_valid, which is registered with no combinational path from out_ready.
  - Skid empty: input bypasses into slot 0 when slot 0 can load. Otherwise the accepted entry goes into the skid.
  - Skid full: slot 0 loads from the skid first. The skid empties in the same cycle.
- Order is preserved strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush, highest priority after rst:
  - All valid bits and skid_valid clear. All ctrl and data registers go to 0. occupancy goes to 0.
  - A transfer-in coinciding with flush is dropped.
  - out_valid and out_ctrl read 0 from the next cycle.
  - in_ready is 1 the cycle after flush.
- occupancy updates as occupancy + in_xfer − out_xfer, saturating is not required (it cannot exceed STAGES+SKID).
- Reset: all outputs 0 (out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 from the first cycle after reset deasserts). rst mid-stream discards all entries identically to flush.

## Timing
- Latency, empty pipe with no stall: an entry accepted at edge t is visible on out_* after edge t+STAGES−1, i.e. the cycle following acceptance when STAGES=1. The skid bypass adds 0 cycles.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Capacity: STAGES+SKID entries. in_ready falls only when all are full (SKID=1: the cycle after the skid fills).
- out_valid/out_ctrl/out_data change only on clock edges and remain stable while out_valid && !out_ready.
- Simultaneous in_xfer and out_xfer with a full pipe (SKID=0) is legal. occupancy is unchanged.

## Test plan
- Stream (STAGES=2, SKID=1): 8 entries, data 0x10..0x17, ctrl 0x001..0x008, out_ready=1. Outputs appear 0x10..0x17 in order, first one 2 cycles after the first accept, one per cycle, occupancy steady at 2.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1. Exactly STAGES+SKID=3 entries are accepted. in_ready=0 from the cycle after the skid fills, out_data holds 0x10. Release gives 0x10,0x11,0x12… in order with no loss or duplicate.
- Bubble collapse (STAGES=3): a single entry with out_ready=0. It reaches the last slot in 3 cycles while occupancy=1 and in_ready stays 1.
- Flush while full: pipe holds 3 entries and in_valid=1 with flush=1. Next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1. The coincident input never emerges.
- Reset mid-stream: assert rst for 1 cycle with 2 entries in flight. All outputs go to 0 next cycle. The next entry, 0xAA, emerges alone after the nominal latency.
- SKID=0 combinational ready: full pipe, toggle out_ready each cycle. in_ready mirrors out_ready in the same cycle and every accepted entry emerges exactly once.
